// File: rtl/inst_fetch_line_buffer_if.sv
// Core-side fetch signals and instruction-memory handshake for the fetch line buffer.
interface inst_fetch_line_buffer_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      pc;
   logic [31:0]      inst;
   logic             stall;
   logic             flush;
   logic             mem_req;
   logic [31:0]      mem_addr;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   logic [CNT_W-1:0] miss_count;

   // Environment side: the core plus the instruction memory.
   modport master (
      output pc, flush, mem_ack, mem_rdata,
      input  inst, stall, mem_req, mem_addr, miss_count
   );

   // Line buffer side.
   modport slave (
      input  pc, flush, mem_ack, mem_rdata,
      output inst, stall, mem_req, mem_addr, miss_count
   );
endinterface

// File: rtl/inst_fetch_line_buffer.sv
// One-line direct-mapped instruction cache in front of the core. A miss stalls the
// core and refills the whole line, word by word in address order, over req/ack.
module inst_fetch_line_buffer #(
   parameter int          LINE_WORDS = 4,
   parameter logic [31:0] NOP_INST   = 32'h0000_0000,
   parameter int          CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   inst_fetch_line_buffer_if.slave bus
);
   localparam int               IDX_W    = $clog2(LINE_WORDS);
   localparam int               OFF      = IDX_W + 2;
   localparam int               TAG_W    = 32 - OFF;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t           state_q, state_d;
   logic             line_valid_q, line_valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic             mem_req_q, mem_req_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic             pending_flush_q, pending_flush_d;
   logic [31:0]      line_q [LINE_WORDS];

   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] pc_idx;
   logic [IDX_W-1:0] cnt_inc;
   logic             unused_pc_bits;
   logic             hit;
   logic             start_refill;
   logic             ack;
   logic             last_ack;
   logic [31:0]      inst;
   logic             stall;

   assign pc_tag         = bus.pc[31:OFF];
   assign pc_idx         = bus.pc[OFF-1:2];
   assign unused_pc_bits = ^bus.pc[1:0];
   assign cnt_inc        = cnt_q + 1'b1;

   // Only an idle, valid line with a matching tag can answer the core.
   assign hit          = (state_q == IDLE) && line_valid_q && (tag_q == pc_tag);
   // A flush in the same cycle wins; the miss is taken on the next cycle instead.
   assign start_refill = (state_q == IDLE) && !hit && !bus.flush;
   // Acks outside a refill are ignored since no request is outstanding.
   assign ack          = (state_q == REFILL) && bus.mem_ack;
   assign last_ack     = ack && (cnt_q == LAST_IDX);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // its inputs from before the edge, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic: one refill per miss, ending on the ack of the last word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_refill) state_d = REFILL;
         REFILL:  if (last_ack)     state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Output logic: the addressed word on a hit, otherwise stall with a NOP.
   always_comb begin
      inst  = NOP_INST;
      stall = 1'b1;
      if (hit) begin
         inst  = line_q[pc_idx];
         stall = 1'b0;
      end
   end

   // Datapath next state: tag capture, word counter, request address, flush tracking.
   // NOTE: every variable gets its hold value first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      line_valid_d    = line_valid_q;
      tag_d           = tag_q;
      cnt_d           = cnt_q;
      miss_count_d    = miss_count_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      pending_flush_d = pending_flush_q;
      if (state_q == IDLE) begin
         if (bus.flush) begin
            line_valid_d = 1'b0;
         end else if (start_refill) begin
            tag_d        = pc_tag;
            line_valid_d = 1'b0;
            cnt_d        = '0;
            mem_req_d    = 1'b1;
            mem_addr_d   = {pc_tag, {IDX_W{1'b0}}, 2'b00};
            if (miss_count_q != {CNT_W{1'b1}}) miss_count_d = miss_count_q + 1'b1;
         end
      end else begin
         // Outstanding acks cannot be aborted, so a flush only poisons the result.
         if (bus.flush) pending_flush_d = 1'b1;
         if (ack) begin
            cnt_d = cnt_inc;
            if (last_ack) begin
               mem_req_d       = 1'b0;
               line_valid_d    = !(pending_flush_q || bus.flush);
               pending_flush_d = 1'b0;
            end else begin
               mem_addr_d = {tag_q, cnt_inc, 2'b00};
            end
         end
      end
   end

   // Datapath registers; the async reset also drops mem_req immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_valid_q    <= 1'b0;
         tag_q           <= '0;
         cnt_q           <= '0;
         miss_count_q    <= '0;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= '0;
         pending_flush_q <= 1'b0;
      end else begin
         line_valid_q    <= line_valid_d;
         tag_q           <= tag_d;
         cnt_q           <= cnt_d;
         miss_count_q    <= miss_count_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         pending_flush_q <= pending_flush_d;
      end
   end

   // Line storage, written in fetch order as each word is acked.
   // NOTE: the line is small and is expected to read as zero after reset, so it is
   // built from resettable flops rather than an unreset RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      end else if (ack) begin
         line_q[cnt_q] <= bus.mem_rdata;
      end
   end

   assign bus.inst       = inst;
   assign bus.stall      = stall;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.miss_count = miss_count_q;
endmodule
